// File: rtl/pnb_pkg.sv
// Shared framing constants and FSM state type for the inter-FPGA PNB SPI link.
// Protocol_analysis reuses the sync and width constants from here.
package pnb_pkg;

    localparam logic [7:0]  PNB_SYNC      = 8'hA5;
    localparam int unsigned PNB_PAYLOAD_W = 41;
    localparam int unsigned PNB_FRAME_W   = 51;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWaitCs,
        StGap
    } pnb_state_e;

    // Sync, source id, payload, then even parity over source id and payload.
    function automatic logic [PNB_FRAME_W-1:0] pnb_build_frame(
        input logic                     src,
        input logic [PNB_PAYLOAD_W-1:0] payload
    );
        return {PNB_SYNC, src, payload, ^{src, payload}};
    endfunction

endpackage

// File: rtl/pnb_tx_scheduler_if.sv
// Requester handshakes, chip select and serial output of the PNB transmit scheduler.
// master = requesters/link side, slave = scheduler.
interface pnb_tx_scheduler_if;
    import pnb_pkg::*;

    logic                     cs;
    logic                     req0_valid;
    logic [PNB_PAYLOAD_W-1:0] req0_data;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [PNB_PAYLOAD_W-1:0] req1_data;
    logic                     req1_ready;
    logic                     dataout;
    logic                     vld;
    logic                     busy;
    logic                     drop_err;

    modport master (
        output cs, req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, dataout, vld, busy, drop_err
    );

    modport slave (
        input  cs, req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, dataout, vld, busy, drop_err
    );

endinterface

// File: rtl/pnb_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on an accepted grant.
module pnb_rr_arb (
    input  logic       sck_i,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_any_o,
    output logic       gnt_idx_o
);

    logic last_q;

    always_comb begin
        gnt_any_o = |req_i;
        // On a tie the requester not served last wins.
        if (&req_i) begin
            gnt_idx_o = ~last_q;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/pnb_tx_scheduler.sv
// Transmit scheduler for the PNB SPI link: arbitrates two requesters, frames the payload
// and streams it MSB first, restarting the frame on chip-select loss up to MAX_RETRY times.
module pnb_tx_scheduler
    import pnb_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP_CYC   = 1
) (
    input logic               sck,
    input logic               rstn,
    pnb_tx_scheduler_if.slave bus
);

    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);
    localparam logic [3:0] GapLast  = 4'(GAP_CYC - 1);
    localparam logic [5:0] LastBit  = 6'(PNB_FRAME_W - 1);

    pnb_state_e               state_q;
    logic [PNB_FRAME_W-1:0]   frame_q;
    logic [5:0]               bitcnt_q;
    logic [2:0]               retry_q;
    logic [3:0]               gapcnt_q;
    logic                     vld_q;
    logic                     dataout_q;
    logic                     busy_q;
    logic                     drop_err_q;

    logic                     gnt_any;
    logic                     gnt_idx;
    logic                     accept;
    logic [PNB_PAYLOAD_W-1:0] gnt_data;
    logic [PNB_FRAME_W-1:0]   new_frame;

    pnb_rr_arb u_arb (
        .sck_i     (sck),
        .rstn_i    (rstn),
        .req_i     ({bus.req1_valid, bus.req0_valid}),
        .accept_i  (accept),
        .gnt_any_o (gnt_any),
        .gnt_idx_o (gnt_idx)
    );

    // Ready is only offered in IDLE with cs low, so a held frame is never overwritten.
    assign accept    = rstn && (state_q == StIdle) && !bus.cs && gnt_any;
    assign gnt_data  = gnt_idx ? bus.req1_data : bus.req0_data;
    assign new_frame = pnb_build_frame(gnt_idx, gnt_data);

    assign bus.req0_ready = accept && !gnt_idx;
    assign bus.req1_ready = accept && gnt_idx;
    assign bus.dataout    = dataout_q;
    assign bus.vld        = vld_q;
    assign bus.busy       = busy_q;
    assign bus.drop_err   = drop_err_q;

    always_ff @(posedge sck) begin
        if (!rstn) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            bitcnt_q   <= '0;
            retry_q    <= '0;
            gapcnt_q   <= '0;
            vld_q      <= 1'b0;
            dataout_q  <= 1'b0;
            busy_q     <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        frame_q   <= new_frame;
                        bitcnt_q  <= '0;
                        retry_q   <= '0;
                        vld_q     <= 1'b1;
                        dataout_q <= new_frame[PNB_FRAME_W-1];
                        busy_q    <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    // bitcnt_q indexes the bit currently on dataout.
                    if (bus.cs) begin
                        vld_q     <= 1'b0;
                        dataout_q <= 1'b0;
                        bitcnt_q  <= '0;
                        state_q   <= StWaitCs;
                    end else if (bitcnt_q == LastBit) begin
                        vld_q     <= 1'b0;
                        dataout_q <= 1'b0;
                        bitcnt_q  <= '0;
                        gapcnt_q  <= '0;
                        state_q   <= StGap;
                    end else begin
                        bitcnt_q  <= bitcnt_q + 6'd1;
                        dataout_q <= frame_q[LastBit - bitcnt_q - 6'd1];
                    end
                end
                StWaitCs: begin
                    if (!bus.cs) begin
                        if (retry_q < MaxRetry) begin
                            retry_q   <= retry_q + 3'd1;
                            vld_q     <= 1'b1;
                            dataout_q <= frame_q[PNB_FRAME_W-1];
                            state_q   <= StShift;
                        end else begin
                            drop_err_q <= 1'b1;
                            gapcnt_q   <= '0;
                            state_q    <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (gapcnt_q == GapLast) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gapcnt_q <= gapcnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pnb_tx_scheduler.sv
// Scoreboard bench for pnb_tx_scheduler: expected frames are queued as requests are driven
// and compared against each complete 51-bit vld burst captured from the serial output.
module tb_pnb_tx_scheduler;

    logic sck;
    logic rstn;

    pnb_tx_scheduler_if bus ();

    pnb_tx_scheduler #(
        .MAX_RETRY (3),
        .GAP_CYC   (1)
    ) dut (
        .sck  (sck),
        .rstn (rstn),
        .bus  (bus)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    int n_checks = 0;
    int n_errs   = 0;

    logic [50:0] exp_q [$];
    logic [50:0] mon_sr;
    int          mon_cnt     = 0;
    int          drops_seen  = 0;
    int          starts_seen = 0;
    logic        prev_vld    = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [50:0] mk_frame(input logic src, input logic [40:0] p);
        return {8'hA5, src, p, ^{src, p}};
    endfunction

    task automatic step();
        @(negedge sck);
    endtask

    // Returns at the sampling point of the cycle whose rising edge accepts a request.
    task automatic wait_accept(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.req0_ready && bus.req0_valid) begin
                idx = 0;
                break;
            end
            if (bus.req1_ready && bus.req1_valid) begin
                idx = 1;
                break;
            end
            @(negedge sck);
            cyc++;
        end
        check("accept_seen", 64'(idx >= 0), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !bus.busy) break;
            step();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Serial capture: partial bursts (aborts, resets) are discarded.
    always @(negedge sck) begin
        logic [50:0] e;
        if (!rstn) begin
            mon_cnt = 0;
        end else if (bus.vld) begin
            mon_sr = {mon_sr[49:0], bus.dataout};
            mon_cnt++;
            if (mon_cnt == 51) begin
                check("frame_queued", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("frame", 64'(mon_sr), 64'(e));
                end
                mon_cnt = 0;
            end
        end else begin
            mon_cnt = 0;
        end
        if (bus.vld && !prev_vld) starts_seen++;
        prev_vld = bus.vld;
        if (bus.drop_err) drops_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, cyc, d0, s0;
        logic        seen;
        logic [40:0] a [4];
        logic [40:0] p, q;

        rstn           = 1'b0;
        bus.cs         = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 41'h1_2345_6789A;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        repeat (3) step();

        // Reset state, readys held low while rstn is low.
        check("rst_vld", 64'(bus.vld), 64'd0);
        check("rst_dataout", 64'(bus.dataout), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_drop", 64'(bus.drop_err), 64'd0);
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);

        // Single frame, hand-computed parity (payload popcount 17).
        exp_q.push_back({8'hA5, 1'b0, 41'h1_2345_6789A, 1'b1});
        rstn = 1'b1;
        wait_accept(idx, cyc);
        check("t1_grant", 64'(idx), 64'd0);
        check("t1_ready_same_cycle", 64'(cyc), 64'd0);
        step();
        bus.req0_valid = 1'b0;
        check("t1_first_vld", 64'(bus.vld), 64'd1);
        check("t1_first_bit", 64'(bus.dataout), 64'd1);
        repeat (50) step();
        check("t1_parity_vld", 64'(bus.vld), 64'd1);
        step();
        check("t1_gap_vld", 64'(bus.vld), 64'd0);
        check("t1_gap_busy", 64'(bus.busy), 64'd1);
        step();
        check("t1_idle_busy", 64'(bus.busy), 64'd0);
        drain();

        // Both requesters held valid from reset: 0,1,0,1 at minimum spacing.
        for (int k = 0; k < 4; k++) a[k] = 41'({$urandom(), $urandom()});
        rstn           = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = a[0];
        bus.req1_valid = 1'b1;
        bus.req1_data  = a[1];
        repeat (2) step();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_frame(1'(k % 2), a[k]));
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_accept(idx, cyc);
            check("rr_grant", 64'(idx), 64'(k % 2));
            if (k > 0) check("rr_spacing", 64'(cyc), 64'd52);
            step();
            if (idx == 0) begin
                if (k < 2) bus.req0_data = a[2];
                else bus.req0_valid = 1'b0;
            end else if (idx == 1) begin
                if (k < 2) bus.req1_data = a[3];
                else bus.req1_valid = 1'b0;
            end
        end
        drain();

        // cs lost at bit 20 for 5 cycles: full resend, no drop.
        p = 41'({$urandom(), $urandom()});
        exp_q.push_back(mk_frame(1'b0, p));
        bus.req0_valid = 1'b1;
        bus.req0_data  = p;
        d0 = drops_seen;
        wait_accept(idx, cyc);
        check("t3_grant", 64'(idx), 64'd0);
        step();
        bus.req0_valid = 1'b0;
        repeat (20) step();
        bus.cs = 1'b1;
        step();
        check("t3_abort_vld", 64'(bus.vld), 64'd0);
        repeat (4) step();
        bus.cs = 1'b0;
        drain();
        check("t3_no_drop", 64'(drops_seen), 64'(d0));

        // Four aborted attempts: three resends then one drop pulse, req1 served next.
        p = 41'({$urandom(), $urandom()});
        q = 41'({$urandom(), $urandom()});
        exp_q.push_back(mk_frame(1'b1, q));
        bus.req0_valid = 1'b1;
        bus.req0_data  = p;
        d0 = drops_seen;
        s0 = starts_seen;
        wait_accept(idx, cyc);
        check("t4_grant0", 64'(idx), 64'd0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = q;
        for (int att = 0; att < 4; att++) begin
            for (int i = 0; i < 100; i++) begin
                if (bus.vld) break;
                step();
            end
            repeat (3) step();
            bus.cs = 1'b1;
            step();
            step();
            if (att == 0) check("t4_wait_ready1", 64'(bus.req1_ready), 64'd0);
            bus.cs = 1'b0;
            if (att == 3) begin
                step();
                check("t4_drop_pulse", 64'(bus.drop_err), 64'd1);
                check("t4_drop_vld", 64'(bus.vld), 64'd0);
                step();
                check("t4_drop_one_cycle", 64'(bus.drop_err), 64'd0);
            end
        end
        wait_accept(idx, cyc);
        check("t4_grant1", 64'(idx), 64'd1);
        step();
        bus.req1_valid = 1'b0;
        drain();
        check("t4_drop_count", 64'(drops_seen - d0), 64'd1);
        check("t4_attempts", 64'(starts_seen - s0), 64'd5);

        // Reset during bit 30 discards the frame; pending req1 wins afterwards.
        p = 41'({$urandom(), $urandom()});
        q = 41'({$urandom(), $urandom()});
        exp_q.push_back(mk_frame(1'b1, q));
        bus.req0_valid = 1'b1;
        bus.req0_data  = p;
        d0 = drops_seen;
        wait_accept(idx, cyc);
        check("t5_grant0", 64'(idx), 64'd0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = q;
        repeat (30) step();
        rstn = 1'b0;
        step();
        check("t5_rst_vld", 64'(bus.vld), 64'd0);
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        check("t5_rst_ready1", 64'(bus.req1_ready), 64'd0);
        check("t5_rst_drop", 64'(bus.drop_err), 64'd0);
        rstn = 1'b1;
        wait_accept(idx, cyc);
        check("t5_grant1", 64'(idx), 64'd1);
        check("t5_grant1_cyc", 64'(cyc), 64'd0);
        step();
        bus.req1_valid = 1'b0;
        drain();
        check("t5_no_drop", 64'(drops_seen), 64'(d0));

        // cs high with both valid: nothing moves; req0 taken as soon as cs falls.
        p = 41'({$urandom(), $urandom()});
        q = 41'({$urandom(), $urandom()});
        exp_q.push_back(mk_frame(1'b0, p));
        exp_q.push_back(mk_frame(1'b1, q));
        bus.cs         = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = p;
        bus.req1_valid = 1'b1;
        bus.req1_data  = q;
        seen = 1'b0;
        repeat (100) begin
            step();
            if (bus.req0_ready || bus.req1_ready || bus.vld) seen = 1'b1;
        end
        check("t6_cs_high_quiet", 64'(seen), 64'd0);
        bus.cs = 1'b0;
        wait_accept(idx, cyc);
        check("t6_grant0", 64'(idx), 64'd0);
        check("t6_grant0_cyc", 64'(cyc), 64'd0);
        step();
        bus.req0_valid = 1'b0;
        wait_accept(idx, cyc);
        check("t6_grant1", 64'(idx), 64'd1);
        step();
        bus.req1_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
